rst_seq_sync: RTL
=================

Name: rst_seq_sync

Overview:
- Parametrised reset synchronizer and release sequencer for one clock domain.
- Synchronizes the async active-low RST through an NUM_STAGES flop chain, then holds reset for a programmable time.
- Releases NUM_OUTS active-low reset outputs one after another, at fixed spacing, so downstream blocks come out of reset in order.
- Also accepts a synchronous software reset request. Sits at the top of each clock domain in place of a plain reset synchronizer.

Parameters:
- NUM_STAGES, 2, synchronizer depth; legal values >=2.
- NUM_OUTS, 4, number of sequenced reset outputs; legal values >=1.
- HOLD_CYCLES, 16, CLK cycles between sync release (or SW request) and release of SYNC_RST[0]; legal values >=1.
- STEP_CYCLES, 8, CLK cycles between releases of SYNC_RST[i] and SYNC_RST[i+1]; legal values >=1.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-low.
- SW_RST_REQ  input  1  synchronous software reset request, level, sampled on CLK rising edge.
- SYNC_RST  output  NUM_OUTS  active-low sequenced resets; bit 0 is released first.
- RST_DONE  output  1  high when all SYNC_RST bits are released.

Behaviour:
- Reset: RST low asynchronously clears the sync chain, all counters and state. SYNC_RST=0 and RST_DONE=0 immediately, with no clock needed.
  - Any RST low pulse, including a single-cycle one, restarts the full sequence.
  - RST low mid-sequence (HOLD/RELEASE/DONE) behaves identically.
- Sync chain: the flops shift in 1 after RST deasserts. sync_rel = last stage. Edge 1 is the first CLK rising edge with RST high; sync_rel is high after edge NUM_STAGES.
- FSM states and transitions:
  - ASSERT: all outputs 0. Go to HOLD on the edge where sync_rel is sampled high (edge NUM_STAGES+1), with cnt=0.
  - HOLD: cnt increments each edge. On the edge where cnt==HOLD_CYCLES-1, set SYNC_RST[0]<=1, idx<=1, cnt<=0. Go to RELEASE, or to DONE if NUM_OUTS==1.
  - RELEASE: cnt increments. On the edge where cnt==STEP_CYCLES-1, set SYNC_RST[idx]<=1, cnt<=0, idx<=idx+1. The edge releasing bit NUM_OUTS-1 also sets RST_DONE<=1 and goes to DONE.
  - DONE: all outputs 1, RST_DONE=1.
- Release timing:
  - SYNC_RST[0] rises at edge NUM_STAGES+HOLD_CYCLES+1.
  - SYNC_RST[i] rises STEP_CYCLES*i edges later.
  - RST_DONE rises on the same edge as SYNC_RST[NUM_OUTS-1].
  - Defaults: 19, 27, 35, 43.
- Release order is monotonic: bit i is never 1 while any lower bit is 0.
- SW_RST_REQ sampled high at edge e in HOLD, RELEASE or DONE: all SYNC_RST<=0, RST_DONE<=0, state HOLD, cnt<=0.
  - SYNC_RST[0] then rises at edge e+HOLD_CYCLES if the request dropped after edge e.
  - While the request stays high, cnt is held at 0, so release is delayed until HOLD_CYCLES edges after the last sampled-high edge.
  - SW_RST_REQ is ignored in ASSERT.
  - If RST and SW_RST_REQ are active together, RST wins.
- Counter width: clog2(max(HOLD_CYCLES,STEP_CYCLES)+1). idx width: clog2(NUM_OUTS+1). No wrap: cnt always clears at its terminal value.
- All outputs are registered; no combinational path from inputs to outputs except the async RST clear.

Optional Feature:
- Macro: RST_SEQ_REV_ASSERT_EN.
- Defined: SW_RST_REQ sampled high at edge e while in DONE enters state REV_ASSERT.
  - At edge e: RST_DONE<=0 and SYNC_RST[NUM_OUTS-1]<=0.
  - Each following bit goes low STEP_CYCLES edges apart, down to bit 0 at edge e+(NUM_OUTS-1)*STEP_CYCLES.
  - That edge enters HOLD with cnt=0.
  - SW_RST_REQ is ignored during REV_ASSERT. Requests in HOLD/RELEASE still assert all outputs immediately.
- Undefined: REV_ASSERT does not exist; every SW request asserts all outputs at once.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum (ASSERT, HOLD, RELEASE, DONE, REV_ASSERT);
  - a clog2-based width function;
  - parameter-legality constants.
- Sub-module rst_sync_chain: NUM_STAGES flop shift register, async cleared by RST, output sync_rel. Instantiated once.

Test Plan:
- Defaults, RST low then released before edge 1 → SYNC_RST = 0000 until edge 18; 0001 at 19, 0011 at 27, 0111 at 35, 1111 plus RST_DONE=1 at 43.
- RST pulsed low for 3 ns at edge 30 (SYNC_RST=0011) → all outputs 0 with no clock edge; full sequence repeats from the new release, first bit at +19 edges.
- In DONE, SW_RST_REQ high for 1 cycle at edge e → outputs 0000 and RST_DONE=0 after e; bit 0 at e+16, bit 3 plus RST_DONE at e+40.
- SW_RST_REQ held high 10 cycles starting during RELEASE → outputs stay 0; bit 0 rises 16 edges after the last sampled-high edge.
- NUM_OUTS=1, HOLD_CYCLES=1, NUM_STAGES=3 → SYNC_RST[0] and RST_DONE both rise at edge 5.
- RST_SEQ_REV_ASSERT_EN defined, SW request at edge e in DONE → bit 3 low at e, bit 2 at e+8, bit 1 at e+16, bit 0 at e+24; bit 0 re-releases at e+40; requests at e+4 are ignored.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the sequenced reset synchronizer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StAssert,
    StHold,
    StRelease,
    StDone,
    StRevAssert
  } rst_seq_state_e;

  // Smallest legal parameter values; smaller requests are clamped up to these.
  localparam int unsigned MinStages = 2;
  localparam int unsigned MinOuts   = 1;
  localparam int unsigned MinCycles = 1;

  // Bits needed to represent every value in 0..max_val (at least one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Asynchronous-assert, synchronous-release flop chain for the incoming reset.
module rst_sync_chain #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_rel
);

  logic [NUM_STAGES-1:0] chain_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchronizer plus ordered release of NUM_OUTS active-low resets.
// Define RST_SEQ_REV_ASSERT_EN to re-assert in reverse order on a SW request from DONE.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_OUTS    = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic [NUM_OUTS-1:0] SYNC_RST,
  output logic                RST_DONE
);

  localparam int unsigned Stages = max2(NUM_STAGES, MinStages);
  localparam int unsigned Outs   = max2(NUM_OUTS, MinOuts);
  localparam int unsigned Hold   = max2(HOLD_CYCLES, MinCycles);
  localparam int unsigned Step   = max2(STEP_CYCLES, MinCycles);

  localparam int unsigned CntW = width_for(max2(Hold, Step));
  localparam int unsigned IdxW = width_for(Outs);

  localparam logic [CntW-1:0] HoldLast = CntW'(Hold - 1);
  localparam logic [CntW-1:0] StepLast = CntW'(Step - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(Outs - 1);

  logic sync_rel;

  rst_sync_chain #(
    .NUM_STAGES (Stages)
  ) u_sync_chain (
    .CLK      (CLK),
    .RST      (RST),
    .sync_rel (sync_rel)
  );

  rst_seq_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [Outs-1:0] sync_rst_q, sync_rst_d;
  logic            rst_done_q, rst_done_d;
  logic            sw_assert;

  // Requests that collapse every output low at once.
`ifdef RST_SEQ_REV_ASSERT_EN
  assign sw_assert = SW_RST_REQ && (state_q inside {StHold, StRelease});
`else
  assign sw_assert = SW_RST_REQ && (state_q inside {StHold, StRelease, StDone});
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sync_rst_d = sync_rst_q;
    rst_done_d = rst_done_q;

    case (state_q)
      StAssert: begin
        sync_rst_d = '0;
        rst_done_d = 1'b0;
        cnt_d      = '0;
        idx_d      = '0;
        if (sync_rel) begin
          state_d = StHold;
        end
      end

      StHold: begin
        if (cnt_q == HoldLast) begin
          sync_rst_d[0] = 1'b1;
          idx_d         = IdxW'(1);
          cnt_d         = '0;
          if (Outs == 1) begin
            rst_done_d = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRelease: begin
        if (cnt_q == StepLast) begin
          sync_rst_d = sync_rst_q | (Outs'(1) << idx_q);
          cnt_d      = '0;
          idx_d      = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            rst_done_d = 1'b1;
            state_d    = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        sync_rst_d = '1;
        rst_done_d = 1'b1;
      end

`ifdef RST_SEQ_REV_ASSERT_EN
      // idx_q counts the bits still released; the highest of them drops next.
      StRevAssert: begin
        rst_done_d = 1'b0;
        if (cnt_q == StepLast) begin
          sync_rst_d = sync_rst_q & ~(Outs'(1) << (idx_q - IdxW'(1)));
          cnt_d      = '0;
          if (idx_q == IdxW'(1)) begin
            idx_d   = '0;
            state_d = StHold;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      default: begin
        state_d    = StAssert;
        sync_rst_d = '0;
        rst_done_d = 1'b0;
        cnt_d      = '0;
        idx_d      = '0;
      end
    endcase

`ifdef RST_SEQ_REV_ASSERT_EN
    if (SW_RST_REQ && (state_q == StDone)) begin
      rst_done_d = 1'b0;
      sync_rst_d = {Outs{1'b1}} >> 1;
      cnt_d      = '0;
      if (Outs == 1) begin
        idx_d   = '0;
        state_d = StHold;
      end else begin
        idx_d   = IdxLast;
        state_d = StRevAssert;
      end
    end
`endif

    if (sw_assert) begin
      sync_rst_d = '0;
      rst_done_d = 1'b0;
      cnt_d      = '0;
      idx_d      = '0;
      state_d    = StHold;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StAssert;
      cnt_q      <= '0;
      idx_q      <= '0;
      sync_rst_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sync_rst_q <= sync_rst_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign SYNC_RST = sync_rst_q;
  assign RST_DONE = rst_done_q;

endmodule
